// File: rtl/lenet_conv_stream.sv
// lenet_conv_stream: streaming KxK valid convolution for the LeNet accelerator.
// Raster-order pixels enter one per transfer. K-1 line buffers and a KxK window
// feed OUT_CH parallel MAC trees. Each channel result is arithmetically shifted
// by SHIFT and saturated to DATA_W signed bits.
// Build option: define LENET_CONV_RELU_EN to clamp negative results to zero.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_pixel  : input pixel stream
//   kernel                      : weights, (c,r,s) at ((c*K+r)*K+s)*DATA_W,
//                                 latched at the first pixel of each frame
//   out_valid/out_ready/out_pixel/out_last : output stream, channel c at [c*DATA_W +: DATA_W]
//   busy                        : frame in progress
module lenet_conv_stream #(
  parameter int DATA_W = 9,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int OUT_CH = 2,
  parameter int SHIFT  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_pixel,
  input  logic [OUT_CH*K*K*DATA_W-1:0]   kernel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_CH*DATA_W-1:0]       out_pixel,
  output logic                           out_last,
  output logic                           busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(K*K);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K-1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic signed [DATA_W-1:0] lb_q    [K-1][IMG_W];
  logic signed [DATA_W-1:0] win_q   [K][K];
  logic signed [DATA_W-1:0] win_d   [K][K];
  logic signed [DATA_W-1:0] col_vec [K];
  logic [OUT_CH*K*K*DATA_W-1:0] kern_q;

  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [OUT_CH*DATA_W-1:0] out_pixel_q, out_pixel_d;
  logic [OUT_CH*DATA_W-1:0] result;

  logic signed [ACC_W-1:0] acc, px_ext, wt_ext, shr, sat;
  logic xfer, first_px, last_px, win_ok;

  assign in_ready  = !out_valid_q || out_ready;
  assign xfer      = in_valid && in_ready;
  assign first_px  = (col_q == '0) && (row_q == '0);
  assign last_px   = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign win_ok    = (col_q >= COL_WIN) && (row_q >= ROW_WIN);
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Column entering the window: row K-1 is the live pixel, lb_q[j] holds row-(j+1).
  // The MAC works on the post-shift window so the result is ready at the same edge.
  always_comb begin
    col_vec[K-1] = $signed(in_pixel);
    for (int unsigned j = 0; j < K-1; j++) col_vec[K-2-j] = lb_q[j][col_q];
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned s = 0; s < K-1; s++) win_d[r][s] = win_q[r][s+1];
      win_d[r][K-1] = col_vec[r];
    end
  end

  always_comb begin
    result = '0;
    acc    = '0;
    px_ext = '0;
    wt_ext = '0;
    shr    = '0;
    sat    = '0;
    for (int unsigned c = 0; c < OUT_CH; c++) begin
      acc = '0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned s = 0; s < K; s++) begin
          px_ext = ACC_W'(win_d[r][s]);
          wt_ext = ACC_W'($signed(kern_q[((c*K+r)*K+s)*DATA_W +: DATA_W]));
          acc    = acc + px_ext * wt_ext;
        end
      end
      shr = acc >>> SHIFT;
      if (shr > SAT_MAX)      sat = SAT_MAX;
      else if (shr < SAT_MIN) sat = SAT_MIN;
      else                    sat = shr;
`ifdef LENET_CONV_RELU_EN
      if (sat < 0) sat = '0;
`else
      sat = sat;
`endif
      result[c*DATA_W +: DATA_W] = sat[DATA_W-1:0];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;
    if (xfer && win_ok) begin
      out_valid_d = 1'b1;
      out_pixel_d = result;
      out_last_d  = last_px;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_RUN;
      S_RUN:   if (xfer && last_px) state_d = S_DRAIN;
      S_DRAIN: begin
        if (xfer)                                      state_d = S_RUN;
        else if (out_valid_q && out_ready && out_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Data storage needs no reset: outputs are gated by counter-derived validity.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb_q[0][col_q] <= $signed(in_pixel);
      for (int unsigned j = 1; j < K-1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned s = 0; s < K; s++) win_q[r][s] <= win_d[r][s];
      if (first_px) kern_q <= kernel;
    end
  end

endmodule
